// File: rtl/pe_pkg.sv
// Shared definitions for the pe_mac_buf processing element: lane width,
// FSM state encoding and the big-endian byte-lane mapping.
package pe_pkg;

  localparam int unsigned PE_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2
  } pe_state_t;

  // Byte address offset to bit-lane index; byte 0 sits in the top byte
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return 2'd3 - a;
  endfunction

endpackage

// File: rtl/pe_dot.sv
// Unsigned LANES-wide dot product of two byte vectors, purely combinational.
module pe_dot
  import pe_pkg::*;
#(
  parameter int unsigned LANES = 16,
  localparam int unsigned VW = LANES * PE_DW,
  localparam int unsigned SW = 2 * PE_DW + $clog2(LANES)
) (
  input  logic [VW-1:0] a,
  input  logic [VW-1:0] b,
  output logic [SW-1:0] sum_c
);

  // Multiply each lane pair and fold into a running sum
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SW'({8'd0, a[i*PE_DW +: PE_DW]} * {8'd0, b[i*PE_DW +: PE_DW]});
    end
  end

endmodule

// File: rtl/pe_mac_buf.sv
// Processing element: shift-loaded A vector, multi-beat dot-product
// accumulation against streamed B, requantise to one byte, store into a
// byte-addressed result buffer with a 1-cycle synchronous read port.
// Optional feature macro: PE_SAT_EN (saturate the stored byte at 0xFF).
module pe_mac_buf
  import pe_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned ACCW  = 24,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned AW    = $clog2(DEPTH * 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           a_in,
  input  logic                  a_shift,
  input  logic [LANES*8-1:0]    b_vec,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  start,
  input  logic [3:0]            beats,
  input  logic [AW-1:0]         addr,
  output logic                  busy,
  output logic                  done,
  input  logic [AW-3:0]         rd_addr,
  output logic [31:0]           rd_data
);

  localparam int unsigned VW = LANES * PE_DW;
  localparam int unsigned SW = 2 * PE_DW + $clog2(LANES);

  pe_state_t        state;
  logic [VW-1:0]    a_reg;
  logic [ACCW-1:0]  acc;
  logic [3:0]       cnt;
  logic [AW-1:0]    addr_q;
  logic             post;
  logic [31:0]      mem [DEPTH];
  logic [SW-1:0]    dot_c;
  logic [7:0]       byte_c;
  logic [4:0]       boff_c;

  pe_dot #(.LANES(LANES)) u_dot (
    .a     (a_reg),
    .b     (b_vec),
    .sum_c (dot_c)
  );

  // Requantise the accumulator to the stored byte and locate its bit lane
  always_comb begin
`ifdef PE_SAT_EN
    byte_c = ((acc >> SHIFT) > ACCW'(255)) ? 8'hFF : 8'(acc >> SHIFT);
`else
    byte_c = 8'(acc >> SHIFT);
`endif
    boff_c = {byte_lane(addr_q[1:0]), 3'b000};
  end

  // Job control FSM, A load register and accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      b_ready <= 1'b0;
      post    <= 1'b0;
    end else begin
      // done trails the buffer write by one cycle; busy falls as done rises
      done <= post;
      post <= 1'b0;
      if (post) busy <= 1'b0;
      if (a_shift && !busy) a_reg <= VW'({a_reg, a_in});
      case (state)
        IDLE: begin
          if (start && !busy) begin
            acc    <= '0;
            cnt    <= beats;
            addr_q <= addr;
            busy   <= 1'b1;
            if (beats != 4'd0) begin
              state   <= ACC;
              b_ready <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        ACC: begin
          if (b_valid && b_ready) begin
            acc <= acc + ACCW'(dot_c);
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state   <= WRITE;
              b_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
          post  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result buffer: byte write on leaving WRITE, read returns pre-write data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (state == WRITE) mem[addr_q[AW-1:2]][boff_c +: 8] <= byte_c;
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_pe_mac_buf.sv
// Directed bench for pe_mac_buf: reset, basic job, byte merge, zero-beat
// job, saturation, backpressure/busy protocol, mid-job reset, byte packing.
module tb_pe_mac_buf;

  localparam int unsigned LANES = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH * 4);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [31:0]          a_in = '0;
  logic                 a_shift = 1'b0;
  logic [LANES*8-1:0]   b_vec = '0;
  logic                 b_valid = 1'b0;
  logic                 b_ready;
  logic                 start = 1'b0;
  logic [3:0]           beats = '0;
  logic [AW-1:0]        addr = '0;
  logic                 busy;
  logic                 done;
  logic [AW-3:0]        rd_addr = '0;
  logic [31:0]          rd_data;

  int errors = 0;
  int checks = 0;

  pe_mac_buf dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .a_shift (a_shift),
    .b_vec   (b_vec),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .start   (start),
    .beats   (beats),
    .addr    (addr),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*8-1:0] fill(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  task automatic load_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      a_in = w;
      a_shift = 1'b1;
      tick();
    end
    a_shift = 1'b0;
  endtask

  task automatic read_word(input int w, output logic [31:0] d);
    rd_addr = (AW-2)'(w);
    tick();
    d = rd_data;
  endtask

  // Launch a job with b_valid held high; lat = cycles from start edge to done
  task automatic run_job(input logic [3:0] nb, input logic [AW-1:0] ad,
                         input logic [LANES*8-1:0] bv, output int lat, output bit seen);
    beats = nb;
    addr = ad;
    b_vec = bv;
    b_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = b_ready;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (b_ready) seen = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rst = 1'b1;
    tick();
    read_word(0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_word0: got %h want 0", d); end
  endtask

  task automatic test_basic();
    int lat;
    bit seen;
    logic [31:0] d;
    load_a(32'h01010101);
    run_job(4'd3, 8'd5, fill(8'd2), lat, seen);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    read_word(1, d);
    checks++; if (d !== 32'h00600000) begin errors++; $display("FAIL basic_word1: got %h want 00600000", d); end
    // second byte into the same word: 16*2 = 0x20 at byte 7 (bits 7:0)
    run_job(4'd1, 8'd7, fill(8'd2), lat, seen);
    read_word(1, d);
    checks++; if (d !== 32'h00600020) begin errors++; $display("FAIL merge_word1: got %h want 00600020", d); end
  endtask

  task automatic test_zero_beats();
    int lat;
    bit seen;
    logic [31:0] d;
    run_job(4'd0, 8'd7, fill(8'd2), lat, seen);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_b_ready: got %b want 0", seen); end
    read_word(1, d);
    checks++; if (d !== 32'h00600000) begin errors++; $display("FAIL zero_word1: got %h want 00600000", d); end
  endtask

  task automatic test_saturation();
    int lat;
    bit seen;
    logic [31:0] d;
    logic [31:0] exp;
`ifdef PE_SAT_EN
    exp = 32'hFF000000;
`else
    exp = 32'h10000000;
`endif
    load_a(32'hFFFFFFFF);
    run_job(4'd1, 8'd0, fill(8'hFF), lat, seen);
    read_word(0, d);
    checks++; if (d !== exp) begin errors++; $display("FAIL sat_word0: got %h want %h", d, exp); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    logic [31:0] d;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_a(32'h01010101);
    beats = 4'd3;
    addr = 8'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      b_valid = (n <= 5) ? pat[n-1] : 1'b0;
      b_vec = b_valid ? fill(8'd1) : fill(8'hFF);
      // protocol abuse while busy: must neither restart nor disturb A
      start = (n == 2);
      a_shift = (n == 2) || (n == 3);
      a_in = 32'hFFFFFFFF;
      if (n == 2) begin
        beats = 4'd0;
        addr = 8'd13;
      end
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    a_shift = 1'b0;
    b_valid = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL bp_latency: got %0d want 7", lat); end
    read_word(3, d);
    checks++; if (d !== 32'h30000000) begin errors++; $display("FAIL bp_word3: got %h want 30000000", d); end
    // A still all ones: 16*1 = 0x10 at byte 14 (bits 15:8)
    run_job(4'd1, 8'd14, fill(8'd1), lat, seen);
    read_word(3, d);
    checks++; if (d !== 32'h30001000) begin errors++; $display("FAIL a_frozen_word3: got %h want 30001000", d); end
  endtask

  task automatic test_reset_mid_job();
    int lat;
    bit seen;
    int nz;
    logic [31:0] d;
    load_a(32'h01010101);
    beats = 4'd3;
    addr = 8'd5;
    b_vec = fill(8'd2);
    b_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL midrst_b_ready: got %b want 0", b_ready); end
    b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    nz = 0;
    for (int w = 0; w < DEPTH; w++) begin
      read_word(w, d);
      if (d !== 32'h0) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL midrst_nonzero_words: got %0d want 0", nz); end
    // A was cleared: a job without reloading stores 0x00 at byte 4
    run_job(4'd1, 8'd4, fill(8'd2), lat, seen);
    load_a(32'h01010101);
    run_job(4'd3, 8'd5, fill(8'd2), lat, seen);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency: got %0d want 5", lat); end
    read_word(1, d);
    checks++; if (d !== 32'h00600000) begin errors++; $display("FAIL midrst_word1: got %h want 00600000", d); end
  endtask

  task automatic test_byte_pack();
    int lat;
    bit seen;
    logic [31:0] d;
    logic [LANES*8-1:0] bv;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_a(32'h01010101);
    for (int k = 0; k < 4; k++) begin
      bv = '0;
      bv[7:0] = vals[k];
      run_job(4'd1, AW'(8 + k), bv, lat, seen);
    end
    read_word(2, d);
    checks++; if (d !== 32'h11223344) begin errors++; $display("FAIL pack_word2: got %h want 11223344", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_beats();
    test_saturation();
    test_backpressure();
    test_reset_mid_job();
    test_byte_pack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
